// File: rtl/placar_pkg.sv
// Shared types for the scoreboard digit capture block:
// image geometry, pixel/image types, FSM states, binarization helper.
package placar_pkg;

   localparam int TAM_DIGITO  = 11;
   localparam int MAX_DIGITOS = 7;

   typedef logic [7:0] pixel_t;
   typedef pixel_t [10:0][10:0] digito_img_t;
   typedef digito_img_t [7:1] placar_img_t;

   typedef enum logic [1:0] {
      OCIOSO,
      CAPTURANDO,
      CONCLUIDO
   } estado_t;

   function automatic pixel_t binariza(
      input pixel_t lum,
      input pixel_t limiar,
      input bit     en
   );
      if (!en) return lum;
      return (lum >= limiar) ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/placar_captura_if.sv
// Pixel stream in, captured digit images and status out.
// master drives the pixel stream; slave is the capture block.
interface placar_captura_if;
   import placar_pkg::*;

   logic        habilitar;
   logic        inicio_quadro;
   logic        pixel_valido;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   pixel_t      pixel_lum;
   placar_img_t numero;
   logic        pronto;
   logic        ocupado;

   modport master (
      output habilitar, inicio_quadro, pixel_valido,
      output pixel_x, pixel_y, pixel_lum,
      input  numero, pronto, ocupado
   );

   modport slave (
      input  habilitar, inicio_quadro, pixel_valido,
      input  pixel_x, pixel_y, pixel_lum,
      output numero, pronto, ocupado
   );

endinterface

// File: rtl/placar_janela.sv
// Maps a pixel coordinate onto a digit window: hit flag,
// 1-based digit index, row and column inside the 11x11 window.
module placar_janela
   import placar_pkg::*;
#(
   parameter int         NUM_DIGITOS = 3,
   parameter logic [9:0] ORIGEM_X    = 10'd520,
   parameter logic [9:0] ORIGEM_Y    = 10'd20,
   parameter logic [9:0] PASSO_X     = 10'd12
) (
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic       hit,
   output logic [2:0] digito,
   output logic [3:0] linha,
   output logic [3:0] coluna
);

   logic [9:0]  dy;
   logic [10:0] base;
   logic [10:0] dx;
   logic        dentro_y;

   always_comb begin
      hit      = 1'b0;
      digito   = '0;
      coluna   = '0;
      base     = '0;
      dx       = '0;
      dy       = pixel_y - ORIGEM_Y;
      dentro_y = (pixel_y >= ORIGEM_Y) &&
                 (dy <= 10'(TAM_DIGITO - 1));
      linha    = dy[3:0];
      // pitch >= 11 keeps windows disjoint, so at most one matches
      for (int d = 1; d <= NUM_DIGITOS; d++) begin
         base = {1'b0, ORIGEM_X} +
                11'((d - 1) * int'(PASSO_X));
         dx   = {1'b0, pixel_x} - base;
         if (dentro_y && ({1'b0, pixel_x} >= base) &&
             (dx <= 11'(TAM_DIGITO - 1))) begin
            hit    = 1'b1;
            digito = 3'(d);
            coluna = dx[3:0];
         end
      end
   end

endmodule

// File: rtl/placar_captura.sv
// Captures up to seven 11x11 digit windows from a pixel stream.
// Define PLACAR_BINARIZAR_EN to store thresholded pixels (00/FF).
module placar_captura
   import placar_pkg::*;
#(
   parameter int         NUM_DIGITOS = 3,
   parameter logic [9:0] ORIGEM_X    = 10'd520,
   parameter logic [9:0] ORIGEM_Y    = 10'd20,
   parameter logic [9:0] PASSO_X     = 10'd12,
   parameter pixel_t     LIMIAR      = 8'd128
) (
   input logic clock,
   input logic reset,
   placar_captura_if.slave bus
);

`ifdef PLACAR_BINARIZAR_EN
   localparam bit BIN_EN = 1'b1;
`else
   localparam bit BIN_EN = 1'b0;
`endif

   localparam logic [9:0] TOTAL =
      10'(NUM_DIGITOS * TAM_DIGITO * TAM_DIGITO);

   estado_t     estado, estado_prox;
   logic [9:0]  contador, conta_prox;
   placar_img_t work, work_prox, numero;
   logic        hit, novo, captura;
   logic [2:0]  digito;
   logic [3:0]  linha, coluna;
   pixel_t      valor;

   placar_janela #(
      .NUM_DIGITOS (NUM_DIGITOS),
      .ORIGEM_X    (ORIGEM_X),
      .ORIGEM_Y    (ORIGEM_Y),
      .PASSO_X     (PASSO_X)
   ) u_janela (
      .pixel_x (bus.pixel_x),
      .pixel_y (bus.pixel_y),
      .hit     (hit),
      .digito  (digito),
      .linha   (linha),
      .coluna  (coluna)
   );

   always_comb begin
      // a pixel sharing the frame-start cycle joins the new frame
      novo = bus.inicio_quadro &&
             ((estado == CAPTURANDO) ||
              ((estado == OCIOSO) && bus.habilitar));
      captura = bus.pixel_valido && hit &&
                (novo || (estado == CAPTURANDO));
      valor = binariza(bus.pixel_lum, LIMIAR, BIN_EN);
      conta_prox = (novo ? 10'd0 : contador) +
                   10'(captura);
      work_prox = work;
      if (captura)
         work_prox[digito][linha][coluna] = valor;
      estado_prox = estado;
      unique case (estado)
         OCIOSO:
            if (novo) estado_prox = CAPTURANDO;
         CAPTURANDO:
            if (captura && (conta_prox == TOTAL))
               estado_prox = CONCLUIDO;
         CONCLUIDO:
            estado_prox = OCIOSO;
         default:
            estado_prox = OCIOSO;
      endcase
   end

   // numero takes the merged buffer so it is valid while pronto is high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= OCIOSO;
         contador <= '0;
         work     <= '0;
         numero   <= '0;
      end else begin
         estado   <= estado_prox;
         contador <= (estado_prox == CAPTURANDO) ?
                     conta_prox : '0;
         work     <= work_prox;
         if (estado_prox == CONCLUIDO)
            numero <= work_prox;
      end
   end

   assign bus.numero  = numero;
   assign bus.pronto  = (estado == CONCLUIDO);
   assign bus.ocupado = (estado == CAPTURANDO);

endmodule

// File: tb/tb_placar_captura.sv
// Bench for placar_captura: table of single-pixel frames,
// directed corner sequences and random frames against a model.
module tb_placar_captura;
   import placar_pkg::*;

   localparam int ND  = 3;
   localparam int OX  = 520;
   localparam int OY  = 20;
   localparam int PX  = 12;
   localparam int LIM = 128;
   localparam int WPIX = ND * 121;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   placar_captura_if bus();

   placar_captura #(
      .NUM_DIGITOS (ND),
      .ORIGEM_X    (10'(OX)),
      .ORIGEM_Y    (10'(OY)),
      .PASSO_X     (10'(PX)),
      .LIMIAR      (8'(LIM))
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int pulsos = 0;

   pixel_t m_work [1:7][0:10][0:10];
   pixel_t m_num  [1:7][0:10][0:10];
   int     m_estado;
   int     m_cnt;

   typedef struct {
      int     x;
      int     y;
      pixel_t lum;
      int     d;
      int     r;
      int     c;
   } vec_t;

   vec_t tab [10];

   function automatic int janela(
      input int x, input int y,
      output int r, output int c
   );
      int d;
      r = 0;
      c = 0;
      if (y < OY || y > OY + 10 || x < OX) return 0;
      d = (x - OX) / PX + 1;
      c = (x - OX) % PX;
      if (c > 10 || d > ND) return 0;
      r = y - OY;
      return d;
   endfunction

   function automatic pixel_t guarda(input pixel_t l);
`ifdef PLACAR_BINARIZAR_EN
      return (int'(l) >= LIM) ? 8'hFF : 8'h00;
`else
      return l;
`endif
   endfunction

   task automatic chk(input string nome,
                      input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nome, act, exp);
      end
   endtask

   task automatic chk_num(input string nome);
      int e = 0;
      for (int d = 1; d <= 7; d++)
         for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++)
               if (bus.numero[d][r][c] !== m_num[d][r][c]) begin
                  if (e == 0)
                     $display("FAIL %s: numero[%0d][%0d][%0d]=%0h expected %0h",
                              nome, d, r, c, bus.numero[d][r][c],
                              m_num[d][r][c]);
                  e++;
               end
      checks++;
      if (e != 0) errors++;
   endtask

   function automatic int soma();
      int s = 0;
      for (int d = 1; d <= 7; d++)
         for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++)
               s += int'(bus.numero[d][r][c]);
      return s;
   endfunction

   task automatic modelo_limpa();
      m_estado = 0;
      m_cnt    = 0;
      for (int d = 1; d <= 7; d++)
         for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) begin
               m_work[d][r][c] = 8'h00;
               m_num[d][r][c]  = 8'h00;
            end
   endtask

   // 0 idle, 1 capturing, 2 done (one cycle)
   task automatic modelo_passo(input bit v, input int x,
                               input int y, input pixel_t l,
                               input bit ini, input bit hab);
      int d, r, c;
      if (m_estado == 2) begin
         m_estado = 0;
         return;
      end
      if (ini && (m_estado == 1 || hab)) begin
         m_estado = 1;
         m_cnt    = 0;
      end
      if (m_estado == 1 && v) begin
         d = janela(x, y, r, c);
         if (d != 0) begin
            m_work[d][r][c] = guarda(l);
            m_cnt++;
            if (m_cnt == WPIX) begin
               m_estado = 2;
               m_num    = m_work;
            end
         end
      end
   endtask

   task automatic ciclo(input bit v, input int x, input int y,
                        input pixel_t l, input bit ini,
                        input bit hab);
      bus.pixel_valido  = v;
      bus.pixel_x       = 10'(x);
      bus.pixel_y       = 10'(y);
      bus.pixel_lum     = l;
      bus.inicio_quadro = ini;
      bus.habilitar     = hab;
      @(posedge clock);
      modelo_passo(v, x, y, l, ini, hab);
      #1;
      chk("pronto", int'(bus.pronto), int'(m_estado == 2));
      chk("ocupado", int'(bus.ocupado), int'(m_estado == 1));
      if (bus.pronto === 1'b1) pulsos++;
      if (m_estado == 2) chk_num("numero_pronto");
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) ciclo(0, 0, 0, 8'h00, 0, 0);
   endtask

   task automatic pulso_reset();
      #2 reset = 1'b1;
      #1;
      modelo_limpa();
      chk("reset_pronto", int'(bus.pronto), 0);
      chk("reset_ocupado", int'(bus.ocupado), 0);
      chk_num("reset_numero");
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // raster scan of window pixels only; first one carries inicio_quadro
   task automatic quadro(input bit aleat_lum, input pixel_t k,
                         input int sx, input int sy,
                         input pixel_t sl, input int limite,
                         input bit aleat);
      int n = 0;
      int r, c, x;
      bit prim = 1'b1;
      bit hab;
      pixel_t l;
      if (sx >= 0 && janela(sx, sy, r, c) == 0) begin
         ciclo(1, sx, sy, sl, 1, 1);
         prim = 1'b0;
      end
      for (int y = OY; y <= OY + 10; y++)
         for (int d = 1; d <= ND; d++)
            for (int cc = 0; cc <= 10; cc++) begin
               if (n == limite) return;
               x = OX + (d - 1) * PX + cc;
               l = aleat_lum ? 8'($urandom) : k;
               if (x == sx && y == sy) l = sl;
               hab = aleat ? 1'($urandom_range(0, 1)) : 1'b1;
               if (prim) hab = 1'b1;
               if (aleat && !prim) begin
                  if ($urandom_range(0, 5) == 0)
                     ciclo(0, x, y, 8'($urandom), 0, hab);
                  if ($urandom_range(0, 5) == 0)
                     ciclo(1, OX + d * PX - 1 +
                           ((d == ND) ? $urandom_range(0, 30) : 0),
                           y, 8'($urandom), 0, hab);
               end
               ciclo(1, x, y, l, prim, hab);
               prim = 1'b0;
               n++;
            end
   endtask

   pixel_t e127, e128;

   initial begin
      tab[0] = '{532, 25, 8'h33, 2, 5, 0};
      tab[1] = '{520, 20, 8'h11, 1, 0, 0};
      tab[2] = '{530, 30, 8'h22, 1, 10, 10};
      tab[3] = '{554, 30, 8'h44, 3, 10, 10};
      tab[4] = '{544, 20, 8'hC5, 3, 0, 0};
      tab[5] = '{531, 25, 8'h66, 0, 0, 0};
      tab[6] = '{543, 25, 8'h77, 0, 0, 0};
      tab[7] = '{556, 25, 8'h88, 0, 0, 0};
      tab[8] = '{520, 19, 8'h99, 0, 0, 0};
      tab[9] = '{520, 31, 8'hAA, 0, 0, 0};

      bus.pixel_valido  = 1'b0;
      bus.pixel_x       = '0;
      bus.pixel_y       = '0;
      bus.pixel_lum     = '0;
      bus.inicio_quadro = 1'b0;
      bus.habilitar     = 1'b0;
      modelo_limpa();
      pulso_reset();
      ocioso(2);

      // full frame of 5A
      pulsos = 0;
      quadro(0, 8'h5A, -1, 0, 8'h00, WPIX, 0);
      chk("pronto_latencia", int'(bus.pronto), 1);
      chk("n1_00", int'(bus.numero[1][0][0]), int'(guarda(8'h5A)));
      chk("n3_aa", int'(bus.numero[3][10][10]), int'(guarda(8'h5A)));
      chk("n4_zero", int'(bus.numero[4][0][0]), 0);
      chk("n7_zero", int'(bus.numero[7][10][10]), 0);
      ciclo(0, 0, 0, 8'h00, 0, 1);
      chk("pronto_unico", int'(bus.pronto), 0);
      ocioso(2);
      chk("pulsos_5a", pulsos, 1);
      chk_num("numero_5a");

      // one marked pixel per frame, rest 00
      for (int i = 0; i < 10; i++) begin
         pulsos = 0;
         quadro(0, 8'h00, tab[i].x, tab[i].y, tab[i].lum,
                WPIX, 0);
         ocioso(2);
         chk("tab_pulsos", pulsos, 1);
         if (tab[i].d != 0)
            chk("tab_byte",
                int'(bus.numero[tab[i].d][tab[i].r][tab[i].c]),
                int'(guarda(tab[i].lum)));
         chk("tab_soma", soma(),
             (tab[i].d != 0) ? int'(guarda(tab[i].lum)) : 0);
         chk_num("tab_numero");
      end

      // restart after 200 pixels
      pulsos = 0;
      quadro(1, 8'h00, -1, 0, 8'h00, 200, 0);
      quadro(0, 8'h3C, -1, 0, 8'h00, WPIX, 0);
      ocioso(2);
      chk("restart_pulsos", pulsos, 1);
      chk("restart_byte", int'(bus.numero[2][7][3]),
          int'(guarda(8'h3C)));
      chk_num("restart_numero");

      // reset in the middle of a capture
      pulsos = 0;
      quadro(1, 8'h00, -1, 0, 8'h00, 150, 0);
      pulso_reset();
      ocioso(3);
      chk("rst_pulsos", pulsos, 0);
      quadro(0, 8'h21, -1, 0, 8'h00, WPIX, 0);
      ocioso(2);
      chk("rst_recaptura", pulsos, 1);
      chk("rst_byte", int'(bus.numero[1][4][4]),
          int'(guarda(8'h21)));

      // frame start without habilitar
      pulsos = 0;
      ciclo(1, OX, OY, 8'h77, 1, 0);
      chk("hab0_ocupado", int'(bus.ocupado), 0);
      for (int i = 1; i <= 5; i++)
         ciclo(1, OX + i, OY, 8'h77, 0, 1);
      chk("hab0_pulsos", pulsos, 0);
      chk("hab0_byte", int'(bus.numero[1][0][1]),
          int'(guarda(8'h21)));

      // random frames with gaps, strays and habilitar toggling
      pulsos = 0;
      for (int i = 0; i < 6; i++) begin
         quadro(1, 8'h00, -1, 0, 8'h00, WPIX, 1);
         ocioso(1 + $urandom_range(0, 2));
      end
      chk("rand_pulsos", pulsos, 6);
      chk_num("rand_numero");

      // threshold boundary
`ifdef PLACAR_BINARIZAR_EN
      e127 = 8'h00;
      e128 = 8'hFF;
`else
      e127 = 8'h7F;
      e128 = 8'h80;
`endif
      quadro(0, 8'h00, OX, OY, 8'd127, WPIX, 0);
      ocioso(1);
      chk("lum127", int'(bus.numero[1][0][0]), int'(e127));
      quadro(0, 8'h00, OX, OY, 8'd128, WPIX, 0);
      ocioso(1);
      chk("lum128", int'(bus.numero[1][0][0]), int'(e128));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
